// File: rtl/io_port_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : io_port_bridge_if
// Description : Bundle of the host and CPU side signals of io_port_bridge.
//               The bridge connects through the slave modport. The CPU/host
//               agent (board logic or testbench) connects through master.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : AW - output FIFO pointer width (out_count is AW+1 bits)
// Signals     : host_in_*  - host -> CPU word stream (valid/ready)
//               cpu_in_*   - CPU `in` port: data, avail flag, read strobe
//               cpu_out_*  - CPU `out` port: write data and strobe
//               host_out_* - output FIFO head stream (valid/ready)
//               out_count, overflow, underflow - status
//               cpu_stall  - only when IO_PORT_STALL_EN is defined
// Macros      : IO_PORT_STALL_EN - adds cpu_stall instead of drop/underflow
// ============================================================================
interface io_port_bridge_if #(
    parameter int AW = 2
);
    logic [15:0] host_in_data;
    logic        host_in_valid;
    logic        host_in_ready;
    logic [15:0] cpu_in_data;
    logic        cpu_in_avail;
    logic        cpu_in_re;
    logic [15:0] cpu_out_data;
    logic        cpu_out_we;
    logic [15:0] host_out_data;
    logic        host_out_valid;
    logic        host_out_ready;
    logic [AW:0] out_count;
    logic        overflow;
    logic        underflow;
`ifdef IO_PORT_STALL_EN
    logic        cpu_stall;
`endif

    modport slave (
        input  host_in_data, host_in_valid, cpu_in_re,
        input  cpu_out_data, cpu_out_we, host_out_ready,
        output host_in_ready, cpu_in_data, cpu_in_avail,
        output host_out_data, host_out_valid, out_count,
`ifdef IO_PORT_STALL_EN
        output cpu_stall,
`endif
        output overflow, underflow
    );

    modport master (
        output host_in_data, host_in_valid, cpu_in_re,
        output cpu_out_data, cpu_out_we, host_out_ready,
        input  host_in_ready, cpu_in_data, cpu_in_avail,
        input  host_out_data, host_out_valid, out_count,
`ifdef IO_PORT_STALL_EN
        input  cpu_stall,
`endif
        input  overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/io_port_bridge.sv
`default_nettype none
// ============================================================================
// Module      : io_port_bridge
// Description : Host-side counterpart of the CPU 16-bit `in`/`out` ports.
//               A single-entry holding register feeds host words to the CPU
//               `in` port. Every CPU `out` write is captured in a circular
//               FIFO that the host drains over a valid/ready stream.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : DEPTH - output FIFO entries (power of two, 2..16)
//               AW    - log2(DEPTH)
// Ports       : clock - system clock, rising edge
//               reset - synchronous, active-high
//               bus   - io_port_bridge_if.slave (see interface header)
// Macros      : IO_PORT_STALL_EN - when defined, cpu_stall holds the CPU on
//               a read with no word or a write to a full FIFO; overflow and
//               underflow then stay 0. Undefined: words are dropped and the
//               sticky flags record it.
// ============================================================================
module io_port_bridge #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  wire logic          clock,
    input  wire logic          reset,
    io_port_bridge_if.slave    bus
);

    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);
    localparam logic [AW:0] c_one   = (AW+1)'(1);

    // ------------------------------------------------------------------
    // Input holding register
    // ------------------------------------------------------------------
    logic [15:0] r_in_data;
    logic        r_in_avail;
    logic        w_in_ready;
    logic        w_in_xfer;
    logic        w_in_miss;

    // A consume in the same cycle frees the slot, giving 1 word/cycle.
    assign w_in_ready = !r_in_avail || bus.cpu_in_re;
    assign w_in_xfer  = bus.host_in_valid && w_in_ready;
    assign w_in_miss  = bus.cpu_in_re && !r_in_avail;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_in_data  <= 16'h0000;
            r_in_avail <= 1'b0;
        end else if (w_in_xfer) begin
            r_in_data  <= bus.host_in_data;
            r_in_avail <= 1'b1;
        end else if (bus.cpu_in_re) begin
            // Data is deliberately retained after consumption.
            r_in_avail <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [15:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_out_block;

    assign w_full      = (r_count == c_depth);
    assign w_pop       = (r_count != '0) && bus.host_out_ready;
    // A pop in the same cycle makes room, so a full FIFO still accepts.
    assign w_push      = bus.cpu_out_we && (!w_full || w_pop);
    assign w_out_block = bus.cpu_out_we && w_full && !w_pop;

    // Pointers are AW bits wide and DEPTH is 2**AW, so they wrap naturally.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 16'h0000;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= bus.cpu_out_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_one;
                2'b01:   r_count <= r_count - c_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Error handling: sticky flags (default) or stall (optional)
    // ------------------------------------------------------------------
    logic w_set_underflow;
    logic w_set_overflow;
    logic r_underflow;
    logic r_overflow;

`ifdef IO_PORT_STALL_EN
    // The CPU holds its strobe while stalled, so nothing is ever lost and
    // the sticky flags can never be set.
    assign bus.cpu_stall   = w_in_miss || w_out_block;
    assign w_set_underflow = 1'b0;
    assign w_set_overflow  = 1'b0;
`else
    assign w_set_underflow = w_in_miss;
    assign w_set_overflow  = w_out_block;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_set_underflow) begin
                r_underflow <= 1'b1;
            end
            if (w_set_overflow) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.host_in_ready  = w_in_ready;
    assign bus.cpu_in_data    = r_in_data;
    assign bus.cpu_in_avail   = r_in_avail;
    assign bus.host_out_data  = r_mem[r_rd_ptr];
    assign bus.host_out_valid = (r_count != '0);
    assign bus.out_count      = r_count;
    assign bus.overflow       = r_overflow;
    assign bus.underflow      = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_io_port_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_port_bridge
// Description : Directed self-checking bench for io_port_bridge (DEPTH=4).
//               Inputs change 1 time unit after the rising edge; outputs are
//               sampled at the same point, well away from the next edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_port_bridge;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;

    io_port_bridge_if #(.AW(AW)) bus ();

    io_port_bridge #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.host_in_data   = 16'h0000;
        bus.host_in_valid  = 1'b0;
        bus.cpu_in_re      = 1'b0;
        bus.cpu_out_data   = 16'h0000;
        bus.cpu_out_we     = 1'b0;
        bus.host_out_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic cpu_write(input logic [15:0] d);
        bus.cpu_out_data = d;
        bus.cpu_out_we   = 1'b1;
        tick();
        bus.cpu_out_we   = 1'b0;
    endtask

    // Pop the head each cycle, comparing against the expected word first.
    task automatic drain(input logic [15:0] w0, input logic [15:0] w1,
                         input logic [15:0] w2, input logic [15:0] w3);
        logic [15:0] exp_words [4];
        exp_words[0] = w0;
        exp_words[1] = w1;
        exp_words[2] = w2;
        exp_words[3] = w3;
        bus.host_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_valid_%0d", i), {31'd0, bus.host_out_valid}, 32'd1);
            check($sformatf("drain_data_%0d", i), {16'd0, bus.host_out_data}, {16'd0, exp_words[i]});
            tick();
        end
        bus.host_out_ready = 1'b0;
        #1;
        check("drain_count_end", {29'd0, bus.out_count}, 32'd0);
        check("drain_valid_end", {31'd0, bus.host_out_valid}, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        idle_inputs();
        do_reset();

        // ---------------- Reset state ----------------
        check("rst_cpu_in_data",   {16'd0, bus.cpu_in_data}, 32'h0);
        check("rst_cpu_in_avail",  {31'd0, bus.cpu_in_avail}, 32'd0);
        check("rst_host_in_ready", {31'd0, bus.host_in_ready}, 32'd1);
        check("rst_out_valid",     {31'd0, bus.host_out_valid}, 32'd0);
        check("rst_out_data",      {16'd0, bus.host_out_data}, 32'h0);
        check("rst_out_count",     {29'd0, bus.out_count}, 32'd0);
        check("rst_overflow",      {31'd0, bus.overflow}, 32'd0);
        check("rst_underflow",     {31'd0, bus.underflow}, 32'd0);

        // ---------------- Input stream 0x1234, 0xBEEF ----------------
        bus.host_in_data  = 16'h1234;
        bus.host_in_valid = 1'b1;
        #1;
        check("in_ready_empty", {31'd0, bus.host_in_ready}, 32'd1);
        tick();
        check("in_data_1234",  {16'd0, bus.cpu_in_data}, 32'h1234);
        check("in_avail_1",    {31'd0, bus.cpu_in_avail}, 32'd1);
        bus.host_in_data = 16'hBEEF;
        bus.cpu_in_re    = 1'b1;
        #1;
        check("in_ready_b2b", {31'd0, bus.host_in_ready}, 32'd1);
        tick();
        check("in_data_beef",  {16'd0, bus.cpu_in_data}, 32'hBEEF);
        check("in_avail_2",    {31'd0, bus.cpu_in_avail}, 32'd1);
        bus.host_in_valid = 1'b0;
        tick();
        bus.cpu_in_re = 1'b0;
        #1;
        check("in_avail_clr",    {31'd0, bus.cpu_in_avail}, 32'd0);
        check("in_data_retain",  {16'd0, bus.cpu_in_data}, 32'hBEEF);
        check("in_no_underflow", {31'd0, bus.underflow}, 32'd0);

        // ---------------- Read with no word ----------------
        bus.cpu_in_re = 1'b1;
`ifdef IO_PORT_STALL_EN
        #1;
        check("stall_on_read", {31'd0, bus.cpu_stall}, 32'd1);
`endif
        tick();
        bus.cpu_in_re = 1'b0;
        tick();
        tick();
`ifdef IO_PORT_STALL_EN
        check("underflow_stays0", {31'd0, bus.underflow}, 32'd0);
`else
        check("underflow_sticky", {31'd0, bus.underflow}, 32'd1);
`endif
        do_reset();
        check("underflow_reset", {31'd0, bus.underflow}, 32'd0);

        // ---------------- Fill, overflow, drain ----------------
        cpu_write(16'h0001);
        check("fifo_latency_valid", {31'd0, bus.host_out_valid}, 32'd1);
        check("fifo_latency_data",  {16'd0, bus.host_out_data}, 32'h0001);
        cpu_write(16'h0002);
        cpu_write(16'h0003);
        cpu_write(16'h0004);
        check("fifo_full_count", {29'd0, bus.out_count}, 32'd4);
`ifndef IO_PORT_STALL_EN
        cpu_write(16'h0005);
        check("fifo_ovf_count", {29'd0, bus.out_count}, 32'd4);
        check("fifo_overflow",  {31'd0, bus.overflow}, 32'd1);
        check("fifo_ovf_head",  {16'd0, bus.host_out_data}, 32'h0001);
`endif
        drain(16'h0001, 16'h0002, 16'h0003, 16'h0004);

        // Pop on empty is ignored.
        bus.host_out_ready = 1'b1;
        tick();
        bus.host_out_ready = 1'b0;
        #1;
        check("pop_empty_count", {29'd0, bus.out_count}, 32'd0);

        // ---------------- Push+pop at count=1 ----------------
        do_reset();
        cpu_write(16'h0042);
        bus.cpu_out_data   = 16'h0043;
        bus.cpu_out_we     = 1'b1;
        bus.host_out_ready = 1'b1;
        tick();
        bus.cpu_out_we     = 1'b0;
        bus.host_out_ready = 1'b0;
        #1;
        check("pp1_count", {29'd0, bus.out_count}, 32'd1);
        check("pp1_head",  {16'd0, bus.host_out_data}, 32'h0043);

        // ---------------- Push+pop when full ----------------
        do_reset();
        cpu_write(16'h0010);
        cpu_write(16'h0011);
        cpu_write(16'h0012);
        cpu_write(16'h0013);
        bus.cpu_out_data   = 16'h00AA;
        bus.cpu_out_we     = 1'b1;
        bus.host_out_ready = 1'b1;
        tick();
        bus.cpu_out_we     = 1'b0;
        bus.host_out_ready = 1'b0;
        #1;
        check("ppf_count",    {29'd0, bus.out_count}, 32'd4);
        check("ppf_overflow", {31'd0, bus.overflow}, 32'd0);
        drain(16'h0011, 16'h0012, 16'h0013, 16'h00AA);

`ifdef IO_PORT_STALL_EN
        // ---------------- Stall on write to full FIFO ----------------
        do_reset();
        cpu_write(16'h0020);
        cpu_write(16'h0021);
        cpu_write(16'h0022);
        cpu_write(16'h0023);
        bus.cpu_out_data = 16'h0055;
        bus.cpu_out_we   = 1'b1;
        #1;
        check("stall_full", {31'd0, bus.cpu_stall}, 32'd1);
        tick();
        check("stall_hold", {31'd0, bus.cpu_stall}, 32'd1);
        check("stall_count", {29'd0, bus.out_count}, 32'd4);
        bus.host_out_ready = 1'b1;
        #1;
        check("stall_release", {31'd0, bus.cpu_stall}, 32'd0);
        tick();
        bus.cpu_out_we     = 1'b0;
        bus.host_out_ready = 1'b0;
        #1;
        check("stall_after_count", {29'd0, bus.out_count}, 32'd4);
        check("stall_overflow",    {31'd0, bus.overflow}, 32'd0);
        drain(16'h0021, 16'h0022, 16'h0023, 16'h0055);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Bound the whole run in case a task ever waits on a stuck clock.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/io_port_bridge.md
Name: io_port_bridge

Overview:
- Host-side counterpart of the CPU's 16-bit `in`/`out` I/O ports.
- Feeds words from an external valid/ready stream into the CPU input port.
- Captures every CPU output-port write into a small FIFO, which the external host drains over a second valid/ready stream.
- Sits between the processor top level and the board/testbench host.

Parameters:
- DEPTH, 4, output FIFO entries; power of two, 2..16.
- AW, 2, FIFO pointer width; must equal log2(DEPTH).

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- host_in_data  in  16  word offered by host to CPU.
- host_in_valid  in  1  host_in_data is valid.
- host_in_ready  out  1  bridge accepts host_in_data this cycle.
- cpu_in_data  out  16  drives CPU `in` port.
- cpu_in_avail  out  1  cpu_in_data holds an unconsumed word.
- cpu_in_re  in  1  CPU consumes cpu_in_data this cycle (register write from `in` port).
- cpu_out_data  in  16  CPU output-register write data.
- cpu_out_we  in  1  CPU output-register write strobe (one cycle per write).
- host_out_data  out  16  head of output FIFO.
- host_out_valid  out  1  FIFO non-empty.
- host_out_ready  in  1  host pops head this cycle.
- out_count  out  AW+1  FIFO occupancy, 0..DEPTH.
- overflow  out  1  sticky: a CPU write was dropped.
- underflow  out  1  sticky: CPU read with no word available.

Behaviour:
- Reset values: cpu_in_data=0, cpu_in_avail=0, FIFO empty, out_count=0, host_out_valid=0, host_out_data=0, overflow=0, underflow=0.
- Reset mid-operation discards the held input word and all FIFO contents.
- Input holding register (single entry):
  - host_in_ready = !cpu_in_avail || cpu_in_re (combinational).
  - Transfer occurs when host_in_valid && host_in_ready. Next cycle: cpu_in_data=host_in_data, cpu_in_avail=1.
  - cpu_in_re with avail=1 and no new transfer: avail clears next cycle; cpu_in_data is retained.
  - cpu_in_re and transfer in the same cycle: the old word is consumed and the new word is loaded. Back-to-back throughput is 1 word/cycle.
  - cpu_in_re with avail=0: underflow set (sticky until reset); CPU sees current cpu_in_data (0 after reset).
- Output FIFO:
  - Circular buffer with read/write pointers that wrap at DEPTH.
  - Push when cpu_out_we && (count<DEPTH || pop).
  - Pop when host_out_valid && host_out_ready.
  - host_out_data = mem[rd_ptr]; host_out_valid = count!=0. Both are combinational from registered state.
  - Latency: a word written at edge N is visible on host_out_data after edge N (1 cycle).
  - Simultaneous push and pop: count unchanged, including when full (push accepted) and when count=1.
  - Push when full without pop: word dropped, overflow set (sticky); FIFO contents and pointers unchanged.
  - Pop when empty is ignored.
- No internal state machine beyond avail flag, pointers, count and sticky flags.
- All data paths are 16 bits with no transformation.

Optional Feature:
- Macro IO_PORT_STALL_EN.
- Defined: adds output cpu_stall (1 bit, combinational).
  - cpu_stall = (cpu_in_re && !cpu_in_avail) || (cpu_out_we && count==DEPTH && !pop).
  - While cpu_stall=1 the CPU holds its strobe. The bridge neither sets underflow/overflow nor drops the word; the access completes in the first cycle stall deasserts.
  - overflow and underflow stay 0 permanently.
- Not defined: no cpu_stall port; drop/underflow behaviour as above.

Test Plan:
- Reset then idle -> all outputs 0, host_in_ready=1, host_out_valid=0.
- Host sends 0x1234 then 0xBEEF with valid held and CPU pulses cpu_in_re on each cycle avail=1 -> CPU sees 0x1234 then 0xBEEF; host_in_ready stays 1 (1 word/cycle); underflow=0.
- cpu_in_re with avail=0 -> underflow=1 and stays 1 until reset; next reset clears it.
- DEPTH=4, host_out_ready=0, CPU writes 0x0001..0x0005 -> out_count=4, overflow=1; host then pops -> receives 0x0001,0x0002,0x0003,0x0004, count returns to 0.
- FIFO full (4 entries), CPU write 0x00AA and host pop in same cycle -> count stays 4, overflow=0, last popped-order word is 0x00AA.
- With IO_PORT_STALL_EN: write to full FIFO -> cpu_stall=1 until a pop; the word is then accepted, nothing dropped, overflow=0.
